mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port 32-bit memory between the CPU instruction-fetch port and the data port.
- The unified RAM behaves as instr_mem and data_mem did in the Harvard build.
- Per-port request/acknowledge handshake, round-robin arbitration on conflict, Avalon-style waitrequest and fixed read latency on the memory side.
- Sits between mips_cpu_harvard (or its stall wrapper) and the unified RAM.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- READ_LATENCY, 1, edges from memory command acceptance to mem_readdata valid; legal range 1..7

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction fetch request; held until i_ack
- i_addr  in  ADDR_WIDTH  fetch address; stable while i_req
- i_rdata  out  DATA_WIDTH  fetched word; valid when i_ack
- i_ack  out  1  one-cycle completion pulse, fetch port
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data address
- d_byteenable  in  4  write/read byte lanes
- d_wdata  in  DATA_WIDTH  write data
- d_rdata  out  DATA_WIDTH  read data; valid when d_ack
- d_ack  out  1  one-cycle completion pulse, data port
- mem_address  out  ADDR_WIDTH  memory address
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_byteenable  out  4  memory byte lanes
- mem_writedata  out  DATA_WIDTH  memory write data
- mem_waitrequest  in  1  memory not ready; command held while high
- mem_readdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async, all outputs): all outputs 0, state IDLE, last_grant = D (so the first tie goes to fetch).
- Reset mid-operation: any in-flight transaction is abandoned. No ack is issued, and no late mem_readdata is captured after reset deasserts.
- All outputs are registered.
- States:
  - IDLE: sample i_req/d_req.
  - ISSUE: command on the memory bus.
  - WAIT: read latency countdown.
  - RESP: ack pulse.
- IDLE transitions:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port opposite last_grant.
  - On grant, latch the port id, address, byteenable, wdata and we; set last_grant; go to ISSUE.
- Instruction grant drives mem_byteenable = 4'b1111, mem_read = 1, mem_write = 0.
- ISSUE:
  - Drive mem_read = !we, mem_write = we and the latched fields.
  - If mem_waitrequest = 1 at the edge, stay in ISSUE with the command unchanged.
  - Otherwise the command is accepted at that edge E:
    - Write: go to RESP.
    - Read: go to WAIT with counter = READ_LATENCY, and drop mem_read/mem_write.
- WAIT:
  - Decrement the counter each edge.
  - At edge E+READ_LATENCY, capture mem_readdata into the granted port's rdata register and go to RESP.
- RESP:
  - Assert the granted port's ack for exactly one cycle; go to IDLE.
  - Requests are ignored in RESP, so a req still high during the ack cycle is never re-granted.
- Timing with no waitrequest: a req first seen at edge N gives ack high in the cycle after edge N+2 (write) or edge N+2+READ_LATENCY (read).
- The non-granted requester waits. Its request is never dropped by the arbiter.
- i_rdata/d_rdata hold their value until the next read for that port completes. A write does not alter d_rdata.
- Only one transaction is outstanding at a time; no pipelining.
- Fairness: with both ports permanently requesting, grants strictly alternate I, D, I, D.
- Requester contract:
  - Deassert req in the ack cycle, or keep it high to request again.
  - Keeping req high yields the next grant no earlier than the following IDLE.
- Protocol violations (fields changing while req is high before grant) are undefined; the arbiter uses latched values only.

Test Plan:
- Reset then single fetch, i_addr = 0xBFC00000, memory word 0x24020005, READ_LATENCY = 1, waitrequest = 0:
  - mem_read is high for one cycle with mem_address = 0xBFC00000 and mem_byteenable = 4'b1111.
  - i_ack pulses 4 cycles after req is seen, with i_rdata = 0x24020005.
  - d_ack stays 0.
- Data write, d_addr = 0x00001000, d_wdata = 0xDEADBEEF, byteenable = 4'b0011:
  - mem_write is high one cycle with matching fields.
  - d_ack pulses 3 cycles after req.
  - A subsequent read of 0x1000 returns d_rdata = 0x0000BEEF when the model honours lanes.
- Simultaneous i_req and d_req both held for 4 transactions after reset:
  - Grant order is I, D, I, D.
  - No ack is ever asserted on both ports in the same cycle.
- mem_waitrequest held high 3 cycles during a read:
  - mem_address, mem_read and mem_byteenable stay stable for 4 cycles.
  - i_ack is delayed by exactly 3 cycles versus the no-wait case.
- READ_LATENCY = 3, memory drives 0x12345678 only at edge E+3 and garbage otherwise: d_rdata = 0x12345678 at d_ack.
- Reset asserted mid-WAIT (async, between edges): all outputs go 0 immediately, no ack follows after release, and busy = 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// CPU-side and memory-side signal bundle for the fetch/data memory port arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it
// (the CPU ports plus the memory responses).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Instruction fetch port
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_ack;

    // Data port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [3:0]            d_byteenable;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ack;

    // Unified memory side
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [3:0]            mem_byteenable;
    logic [DATA_WIDTH-1:0] mem_writedata;
    logic                  mem_waitrequest;
    logic [DATA_WIDTH-1:0] mem_readdata;

    logic                  busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_byteenable, d_wdata,
               mem_waitrequest, mem_readdata,
        output i_rdata, i_ack, d_rdata, d_ack,
               mem_address, mem_read, mem_write, mem_byteenable, mem_writedata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_byteenable, d_wdata,
               mem_waitrequest, mem_readdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
               mem_address, mem_read, mem_write, mem_byteenable, mem_writedata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// One transaction at a time, round-robin on simultaneous requests, waitrequest
// stalls on the command phase and a fixed read latency afterwards.
// Every output is a flop; READ_LATENCY must be in 1..7.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic       PortI   = 1'b0;
    localparam logic       PortD   = 1'b1;
    localparam logic [2:0] LatInit = 3'(READ_LATENCY);

    // Control state
    state_e     state_q, state_d;
    logic       grant_q, grant_d;           // port owning the current transaction
    logic       last_grant_q, last_grant_d; // tie-break memory for round robin
    logic       we_q, we_d;
    logic [2:0] cnt_q, cnt_d;               // read latency countdown

    // Registered outputs
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [3:0]            mem_byteenable_q, mem_byteenable_d;
    logic [DATA_WIDTH-1:0] mem_writedata_q, mem_writedata_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_ack_q, i_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic                  busy_q, busy_d;

    // State register and latched transaction attributes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= PortI;
            last_grant_q <= PortD; // first tie goes to fetch
            we_q         <= 1'b0;
            cnt_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state: arbitration in IDLE, waitrequest stall, latency countdown
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    // Both requesting: serve the port that did not win last time
                    grant_d      = (bus.i_req && bus.d_req) ? ~last_grant_q : bus.d_req;
                    last_grant_d = grant_d;
                    we_d         = (grant_d == PortD) && bus.d_we;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (!bus.mem_waitrequest) begin
                    if (we_q) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatInit;
                    end
                end
            end
            StWait: begin
                // Reaching 1 means this edge is E+READ_LATENCY
                if (cnt_q <= 3'd1) begin
                    state_d = StResp;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next-values: command launch/hold, read capture, ack pulse
    always_comb begin
        mem_address_d    = mem_address_q;
        mem_byteenable_d = mem_byteenable_q;
        mem_writedata_d  = mem_writedata_q;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        i_rdata_d        = i_rdata_q;
        d_rdata_d        = d_rdata_q;
        i_ack_d          = 1'b0;
        d_ack_d          = 1'b0;
        busy_d           = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (state_d == StIssue) begin
                    if (grant_d == PortI) begin
                        mem_address_d    = bus.i_addr;
                        mem_byteenable_d = 4'b1111;
                        mem_writedata_d  = '0;
                        mem_read_d       = 1'b1;
                    end else begin
                        mem_address_d    = bus.d_addr;
                        mem_byteenable_d = bus.d_byteenable;
                        mem_writedata_d  = bus.d_wdata;
                        mem_read_d       = !bus.d_we;
                        mem_write_d      = bus.d_we;
                    end
                end
            end
            StIssue: begin
                // Hold the command while the memory stalls; drop it once accepted
                if (bus.mem_waitrequest) begin
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                end
            end
            StWait: begin
                if (cnt_q <= 3'd1) begin
                    if (grant_q == PortI) begin
                        i_rdata_d = bus.mem_readdata;
                    end else begin
                        d_rdata_d = bus.mem_readdata;
                    end
                end
            end
            StResp: begin
                i_ack_d = (grant_q == PortI);
                d_ack_d = (grant_q == PortD);
            end
            default: begin
            end
        endcase
    end

    // Output registers, all cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address_q    <= '0;
            mem_byteenable_q <= 4'b0000;
            mem_writedata_q  <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            i_rdata_q        <= '0;
            d_rdata_q        <= '0;
            i_ack_q          <= 1'b0;
            d_ack_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            mem_address_q    <= mem_address_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            i_rdata_q        <= i_rdata_d;
            d_rdata_q        <= d_rdata_d;
            i_ack_q          <= i_ack_d;
            d_ack_q          <= d_ack_d;
            busy_q           <= busy_d;
        end
    end

    assign bus.mem_address    = mem_address_q;
    assign bus.mem_byteenable = mem_byteenable_q;
    assign bus.mem_writedata  = mem_writedata_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.i_rdata        = i_rdata_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.i_ack          = i_ack_q;
    assign bus.d_ack          = d_ack_q;
    assign bus.busy           = busy_q;

endmodule
